// File: rtl/seq_detector_param.sv
// Serial pattern detector: pulses `out` when the last LEN enabled samples match a
// loadable pattern under a don't-care mask, and counts matches with saturation.
module seq_detector_param #(
   parameter int unsigned    LEN         = 4,
   parameter bit             OVERLAP     = 1'b1,
   parameter int unsigned    CNT_W       = 8,
   parameter logic [LEN-1:0] RST_PATTERN = LEN'(4'b1010)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in,
   input  logic             load,
   input  logic [LEN-1:0]   pattern,
   input  logic [LEN-1:0]   mask,
   input  logic             clr_cnt,
   output logic             out,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned       FILL_W    = $clog2(LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

   logic [LEN-1:0]    pat_q,  pat_d;
   logic [LEN-1:0]    mask_q, mask_d;
   logic [LEN-1:0]    hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              out_q,  out_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [LEN-1:0]    hist_n;
   logic [FILL_W-1:0] fill_n;
   logic              match;

   // NOTE: every always_comb output gets a default first, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      pat_d   = pat_q;
      mask_d  = mask_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      out_d   = 1'b0;
      count_d = count_q;

      hist_n = LEN'({hist_q, in});
      fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match  = !load && en && (fill_n == FILL_FULL) &&
               (((hist_n ^ pat_q) & mask_q) == '0);

      if (load) begin
         pat_d  = pattern;
         mask_d = mask;
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = hist_n;
         out_d  = match;
         // Non-overlap mode restarts the history window after each hit.
         fill_d = (match && !OVERLAP) ? '0 : fill_n;
      end

      if (clr_cnt) begin
         count_d = '0;
      end else if (match && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= RST_PATTERN;
         mask_q  <= '1;
         hist_q  <= '0;
         fill_q  <= '0;
         out_q   <= 1'b0;
         count_q <= '0;
      end else begin
         pat_q   <= pat_d;
         mask_q  <= mask_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         out_q   <= out_d;
         count_q <= count_d;
      end
   end

   assign out   = out_q;
   assign count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations share one stimulus stream and
// are checked each cycle against a window-of-samples model plus literal expectations.
module tb_seq_detector_param;

   localparam int LEN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, in_s = 1'b0, load = 1'b0, clr_cnt = 1'b0;
   logic [3:0] pattern = 4'h0, mask = 4'h0;
   logic       out0, out1, out2;
   logic [7:0] count0, count1;
   logic [1:0] count2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_detector_param u0 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .load(load), .pattern(pattern),
      .mask(mask), .clr_cnt(clr_cnt), .out(out0), .count(count0));

   seq_detector_param #(.OVERLAP(1'b0)) u1 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .load(load), .pattern(pattern),
      .mask(mask), .clr_cnt(clr_cnt), .out(out1), .count(count1));

   seq_detector_param #(.CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .in(in_s), .load(load), .pattern(pattern),
      .mask(mask), .clr_cnt(clr_cnt), .out(out2), .count(count2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the samples seen since the last restart, oldest first, compared
   // position by position against the pattern.
   bit          m_ov  [3] = '{1'b1, 1'b0, 1'b1};
   int unsigned m_max [3] = '{255, 255, 3};
   bit [3:0]    m_pat [3];
   bit [3:0]    m_msk [3];
   bit          m_seen[3][LEN];
   int          m_n   [3];
   int unsigned m_cnt [3];
   bit          m_out [3];

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit hit;
         hit = 1'b0;
         if (!rst) begin
            m_pat[i] = 4'b1010;
            m_msk[i] = 4'hF;
            m_n[i]   = 0;
            m_cnt[i] = 0;
            m_out[i] = 1'b0;
         end else begin
            if (load) begin
               m_pat[i] = pattern;
               m_msk[i] = mask;
               m_n[i]   = 0;
            end else if (en) begin
               for (int j = 0; j < LEN - 1; j++) m_seen[i][j] = m_seen[i][j+1];
               m_seen[i][LEN-1] = in_s;
               if (m_n[i] < LEN) m_n[i]++;
               if (m_n[i] == LEN) begin
                  hit = 1'b1;
                  for (int j = 0; j < LEN; j++)
                     if (m_msk[i][LEN-1-j] && (m_seen[i][j] != m_pat[i][LEN-1-j])) hit = 1'b0;
               end
               if (hit && !m_ov[i]) m_n[i] = 0;
            end
            m_out[i] = hit;
            if (clr_cnt) m_cnt[i] = 0;
            else if (hit && (m_cnt[i] < m_max[i])) m_cnt[i]++;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("model_out_ov",   {31'd0, out0}, {31'd0, m_out[0]});
      check("model_out_nov",  {31'd0, out1}, {31'd0, m_out[1]});
      check("model_out_c2",   {31'd0, out2}, {31'd0, m_out[2]});
      check("model_cnt_ov",   {24'd0, count0}, m_cnt[0]);
      check("model_cnt_nov",  {24'd0, count1}, m_cnt[1]);
      check("model_cnt_c2",   {30'd0, count2}, m_cnt[2]);
   end

   // One clock of stimulus; pattern/mask carry junk whenever load is low.
   task automatic drive(input logic e, input logic b, input logic ld, input logic [3:0] p,
                        input logic [3:0] m, input logic c);
      @(negedge clk);
      en      = e;
      in_s    = b;
      load    = ld;
      clr_cnt = c;
      pattern = ld ? p : 4'($urandom);
      mask    = ld ? m : 4'($urandom);
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic load_pat(input logic [3:0] p, input logic [3:0] m);
      drive(1'b0, 1'b0, 1'b1, p, m, 1'b0);
   endtask

   // Sample k is b[k]; bit k of each result is that instance's out after sample k.
   task automatic stream(input logic [31:0] b, input int n,
                         output logic [31:0] p0, output logic [31:0] p1, output logic [31:0] p2);
      p0 = '0; p1 = '0; p2 = '0;
      for (int k = 0; k < n; k++) begin
         drive(1'b1, b[k], 1'b0, 4'h0, 4'h0, 1'b0);
         p0[k] = out0;
         p1[k] = out1;
         p2[k] = out2;
      end
   endtask

   initial begin
      logic [31:0] p0, p1, p2;

      repeat (2) @(negedge clk);
      check("reset_out", {31'd0, out0}, 32'd0);
      check("reset_count", {24'd0, count0}, 32'd0);
      rst = 1'b1;

      // 0,1,0,1,0,1,0,0,1,0,1,0 against default 1010
      stream(32'h52A, 12, p0, p1, p2);
      check("default_pulses_ov", p0, 32'h850);
      check("default_pulses_nov", p1, 32'h810);
      check("default_count_ov", {24'd0, count0}, 32'd3);
      check("default_count_nov", {24'd0, count1}, 32'd2);
      check("default_count_c2", {30'd0, count2}, 32'd3);

      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      check("clr_idle", {24'd0, count0}, 32'd0);

      // 0110 full mask, then 0xx0 via mask 1001
      load_pat(4'b0110, 4'hF);
      stream(32'h36, 7, p0, p1, p2);
      check("p0110_pulses_ov", p0, 32'h48);
      check("p0110_pulses_nov", p1, 32'h08);
      load_pat(4'b0110, 4'b1001);
      stream(32'h0, 6, p0, p1, p2);
      check("masked_pulses_ov", p0, 32'h38);
      check("masked_pulses_nov", p1, 32'h08);

      // 1111 with a stream of ones: back-to-back pulses, 2-bit counter saturates
      drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
      load_pat(4'hF, 4'hF);
      stream(32'hFF, 8, p0, p1, p2);
      check("ones_pulses_c2", p2, 32'hF8);
      check("ones_pulses_nov", p1, 32'h88);
      check("ones_sat_c2", {30'd0, count2}, 32'd3);
      check("ones_count_ov", {24'd0, count0}, 32'd5);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
      check("clr_on_match_out", {31'd0, out2}, 32'd1);
      check("clr_on_match_cnt", {30'd0, count2}, 32'd0);

      // all-don't-care mask
      load_pat(4'h0, 4'h0);
      stream(32'h5A, 8, p0, p1, p2);
      check("mask0_pulses_ov", p0, 32'hF8);
      check("mask0_pulses_nov", p1, 32'h88);

      // enable gaps do not break the sequence
      load_pat(4'b1010, 4'hF);
      stream(32'h1, 2, p0, p1, p2);
      repeat (3) idle();
      drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      check("gap_no_early", {31'd0, out0}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      check("gap_match", {31'd0, out0}, 32'd1);

      // mid-stream async reset restores RST_PATTERN and empties the history
      load_pat(4'b0011, 4'hF);
      stream(32'h5, 3, p0, p1, p2);
      #1 rst = 1'b0;
      #1;
      check("async_rst_out", {31'd0, out0}, 32'd0);
      check("async_rst_cnt", {24'd0, count0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      stream(32'h0, 1, p0, p1, p2);
      check("post_rst_single", p0, 32'h0);
      stream(32'h5, 4, p0, p1, p2);
      check("post_rst_full", p0, 32'h8);

      // load wins over a concurrent enabled sample
      drive(1'b1, 1'b1, 1'b1, 4'b1010, 4'hF, 1'b0);
      check("load_en_out", {31'd0, out0}, 32'd0);
      stream(32'h2, 3, p0, p1, p2);
      check("load_en_not_sampled", p0, 32'h0);

      idle();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It is the successor to the fixed 4-bit seqDetector.
- Samples a 1-bit serial stream and pulses `out` when the last LEN sampled bits match a runtime-loadable pattern under a don't-care mask.
- Overlap or non-overlap mode is selected by parameter.
- Keeps a saturating match counter.
- Sits between the serial input conditioning and the lab's status/display logic.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..32.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of match counter; legal range 1..32.
- RST_PATTERN, 4'b1010 (LEN bits), pattern register value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; `in` is consumed only on edges where en=1.
- in  input  1  serial data bit.
- load  input  1  latch pattern/mask and restart detection.
- pattern  input  LEN  new pattern; bit LEN-1 = oldest (first received) bit, bit 0 = newest.
- mask  input  LEN  compare mask; 1 = compare bit, 0 = don't care.
- clr_cnt  input  1  synchronous clear of count.
- out  output  1  registered one-cycle match pulse.
- count  output  CNT_W  number of matches since reset/clear, saturating.

Behaviour:
- Reset, asynchronous on rst=0, all values forced while rst is low:
  - pat_q=RST_PATTERN, mask_q=all ones.
  - hist=0, fill=0, out=0, count=0.
- Internal state:
  - pat_q, mask_q (LEN bits each).
  - hist, a shift register (LEN bits).
  - fill, the number of valid history bits, 0..LEN, width clog2(LEN+1).
- Each rising edge, in priority order:
  1. load=1:
     - pat_q<=pattern, mask_q<=mask.
     - hist<=0, fill<=0, out<=0.
     - `in` and `en` are ignored this cycle.
     - count is unaffected except by clr_cnt.
  2. Else en=1:
     - hist_n={hist[LEN-2:0], in}.
     - fill_n=min(fill+1, LEN).
     - match = (fill_n==LEN) && (((hist_n ^ pat_q) & mask_q)==0).
     - out<=match, hist<=hist_n.
     - fill<=(match && OVERLAP==0) ? 0 : fill_n.
  3. Else (en=0): out<=0; hist and fill hold.
- Latency: out is high in the cycle after the sampling edge that shifts in the final pattern bit. It is never high for more than one cycle per match.
- Consecutive overlapping matches may produce out high on back-to-back cycles, e.g. pattern 1111 with a stream of 1s.
- Counter:
  - On a match, count<=count+1, saturating at 2^CNT_W-1 (holds, no wrap).
  - clr_cnt=1 forces count<=0 and wins over a simultaneous match; out still pulses.
  - load does not clear count.
- Mask all zeros: every sample with fill_n==LEN matches.
  - OVERLAP=1: a match on every enabled sample once LEN bits are seen.
  - OVERLAP=0: one match every LEN samples.
- Patterns are only updated via load; the pattern and mask inputs are ignored otherwise.
- Reset asserted mid-stream discards partial history. Detection restarts from fill=0 with RST_PATTERN.
- en gaps do not break a sequence: history spans only enabled samples.

Test Plan:
- Defaults (1010, overlap), en=1, stream 0,1,0,1,0,1,0,0,1,0,1,0 -> out pulses after samples 5, 7 and 12; count=3.
- OVERLAP=0, same stream -> out pulses after samples 5 and 12 only; count=2.
- load pattern=0110 mask=1111, then stream 0,1,1,0,1,1,0 -> pulses after samples 4 and 7. Then load mask=1001 (pattern x11x→0xx0), stream 0,0,0,0 -> single pulse after sample 4, further pulses on each subsequent sample.
- CNT_W=2, pattern 1111, overlap, stream of eight 1s -> out high for samples 4..8 (5 pulses); count saturates at 3. clr_cnt asserted on a matching edge -> count=0, out=1.
- Enable gaps: stream 1,0,(en=0 for 3 cycles),1,0 -> out pulses after the 4th enabled sample. Assert rst=0 after bits 1,0,1 -> out=0, count=0 immediately. After release, bit 0 alone does not match; full 1,0,1,0 is required.
- load asserted concurrently with en=1, in=1 -> the bit is not sampled, fill=0, out=0 next cycle.
